// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM states, RV32I funct3 codes,
// bus size codes and the request fault decoders.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } lsu_state_e;

  // RV32I load funct3 encodings
  localparam logic [2:0] LSU_F3_LB  = 3'b000;
  localparam logic [2:0] LSU_F3_LH  = 3'b001;
  localparam logic [2:0] LSU_F3_LW  = 3'b010;
  localparam logic [2:0] LSU_F3_LBU = 3'b100;
  localparam logic [2:0] LSU_F3_LHU = 3'b101;

  // RV32I store funct3 encodings
  localparam logic [2:0] LSU_F3_SB  = 3'b000;
  localparam logic [2:0] LSU_F3_SH  = 3'b001;
  localparam logic [2:0] LSU_F3_SW  = 3'b010;

  // The low two funct3 bits of every legal access already equal the size code.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
    if (we) return funct3[2] || (funct3 == 3'b011);
    else    return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      SIZE_HALF: return addr_lo[0];
      SIZE_WORD: return addr_lo != 2'b00;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Combinational load-data extender: sign/zero-extends raw bus data by funct3.
// Shared with the core's forwarding path.
module load_extend
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    data = raw;
    case (funct3)
      LSU_F3_LB:  data = {{24{raw[7]}}, raw[7:0]};
      LSU_F3_LBU: data = {24'h0, raw[7:0]};
      LSU_F3_LH:  data = {{16{raw[15]}}, raw[15:0]};
      LSU_F3_LHU: data = {16'h0, raw[15:0]};
      default:    data = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and the data bus controller: decodes and
// checks requests, sequences one-shot bus strobes and acks the core.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        illegal,
  output logic        timeout,
  output logic        lsu_busy,
  output logic        bus_rd,
  output logic        bus_wd,
  output logic [1:0]  bus_size_in,
  output logic [1:0]  bus_size_out,
  output logic [31:0] bus_addr_in,
  output logic [31:0] bus_addr_out,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  input  logic        bus_busy
);

  lsu_state_e      state;
  logic            req_we;
  logic [2:0]      req_f3;
  logic [TO_W-1:0] to_cnt;
  logic [31:0]     ext_data;
  logic            bus_go;

  load_extend u_load_extend (
    .funct3 (req_f3),
    .raw    (bus_rdata),
    .data   (ext_data)
  );

  assign bus_go   = bus_ready && !bus_busy;
  assign lsu_busy = (state != S_IDLE);

  // Strobes are qualified by the bus handshake in the accepting cycle itself, and
  // derive from the async-reset state so they drop the instant rst is asserted.
  assign bus_wd = (state == S_ISSUE) &&  req_we && bus_go;
  assign bus_rd = ((state == S_ISSUE) && !req_we && bus_go) || (state == S_CAPTURE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      req_we       <= 1'b0;
      req_f3       <= 3'b000;
      to_cnt       <= '0;
      ack          <= 1'b0;
      misaligned   <= 1'b0;
      illegal      <= 1'b0;
      timeout      <= 1'b0;
      rdata        <= 32'h0;
      bus_size_in  <= 2'b00;
      bus_size_out <= 2'b00;
      bus_addr_in  <= 32'h0;
      bus_addr_out <= 32'h0;
      bus_wdata    <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments here, so every register samples pre-edge values
      // and the pulse defaults below are cleanly overridden on RESP entry.
      ack        <= 1'b0;
      misaligned <= 1'b0;
      illegal    <= 1'b0;
      timeout    <= 1'b0;

      case (state)
        S_IDLE: begin
          if (req) begin
            req_we <= we;
            req_f3 <= funct3;
            if (is_illegal(we, funct3)) begin
              illegal <= 1'b1;
              ack     <= 1'b1;
              state   <= S_RESP;
            end else if (is_misaligned(funct3, addr[1:0])) begin
              misaligned <= 1'b1;
              ack        <= 1'b1;
              state      <= S_RESP;
            end else begin
              to_cnt <= '0;
              state  <= S_ISSUE;
              if (we) begin
                bus_addr_in <= addr;
                bus_size_in <= funct3[1:0];
                bus_wdata   <= wdata;
              end else begin
                bus_addr_out <= addr;
                bus_size_out <= funct3[1:0];
              end
            end
          end
        end

        S_ISSUE: begin
          if (bus_go) begin
            if (req_we) begin
              ack   <= 1'b1;
              state <= S_RESP;
            end else begin
              state <= S_CAPTURE;
            end
          end else if (to_cnt == TO_W'(TIMEOUT_CYCLES)) begin
            timeout <= 1'b1;
            ack     <= 1'b1;
            state   <= S_RESP;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        S_CAPTURE: begin
          rdata <= ext_data;
          ack   <= 1'b1;
          state <= S_RESP;
        end

        S_RESP: begin
          // Bus fields are only meaningful for the transaction in flight.
          bus_size_in  <= 2'b00;
          bus_size_out <= 2'b00;
          bus_addr_in  <= 32'h0;
          bus_addr_out <= 32'h0;
          bus_wdata    <= 32'h0;
          state        <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
